// File: rtl/sample_phase_pkg.sv
// Shared state encoding and default sizing for the sample phase generator.
package sample_phase_pkg;

  localparam int unsigned DEF_PHASE_W    = 24;
  localparam int unsigned DEF_ADDR_W     = 8;
  localparam int unsigned DEF_WDOG_LIMIT = 600;

  typedef enum logic [1:0] {
    STOPPED = 2'd0,
    RUNNING = 2'd1,
    STALLED = 2'd2
  } state_e;

endpackage

// File: rtl/edge_sync_rise.sv
// Two-flop synchroniser for an asynchronous level, plus a third flop for
// rising-edge detection; emits a one-cycle pulse per rising edge.
module edge_sync_rise (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic pulse_o
);

  logic s1_q;
  logic s2_q;
  logic s3_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= async_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // Decode of flops only, so the pulse is glitch-free within the cycle.
  assign pulse_o = s2_q & ~s3_q;

endmodule

// File: rtl/sample_phase_gen.sv
// Sample-rate phase accumulator feeding quarter-wave sine table addresses.
// Optional sample-clock watchdog with sticky stall: define SAMPLE_WDOG_EN.
module sample_phase_gen
  import sample_phase_pkg::*;
#(
  parameter int unsigned PHASE_W    = DEF_PHASE_W,
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned WDOG_LIMIT = DEF_WDOG_LIMIT
) (
  input  logic               clk_in,
  input  logic               reset,
  input  logic               sample_clk,
  input  logic               run,
  input  logic [PHASE_W-1:0] ftw,
  input  logic               ftw_load,
  output logic               sample_en,
  output logic               tbl_valid,
  output logic [ADDR_W-1:0]  tbl_addr,
  output logic               tbl_neg,
  output logic               cycle_start,
  output logic               stall
);

  if (ADDR_W + 2 > PHASE_W || WDOG_LIMIT < 2) begin : g_param_chk
    $error("sample_phase_gen: illegal parameter combination");
  end

  state_e             state_q, state_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [PHASE_W-1:0] ftw_shadow_q, ftw_shadow_d;
  logic [PHASE_W-1:0] ftw_active_q, ftw_active_d;
  logic               tbl_valid_q, tbl_valid_d;
  logic [ADDR_W-1:0]  tbl_addr_q, tbl_addr_d;
  logic               tbl_neg_q, tbl_neg_d;
  logic               cycle_start_q, cycle_start_d;
  logic [PHASE_W:0]   sum_c;
  logic [1:0]         quad;
  logic [ADDR_W-1:0]  idx;

  edge_sync_rise u_sample_sync (
    .clk_i   (clk_in),
    .rst_i   (reset),
    .async_i (sample_clk),
    .pulse_o (sample_en)
  );

  assign sum_c = {1'b0, phase_q} + {1'b0, ftw_active_q};

`ifdef SAMPLE_WDOG_EN
  localparam int unsigned WDOG_W = $clog2(WDOG_LIMIT + 1);

  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              stall_q;
`endif

  // Next-state: shadow/active FTW, phase step, table mapping and FSM.
  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    ftw_shadow_d  = ftw_load ? ftw : ftw_shadow_q;
    ftw_active_d  = sample_en ? ftw_shadow_q : ftw_active_q;
    tbl_valid_d   = 1'b0;
    tbl_addr_d    = tbl_addr_q;
    tbl_neg_d     = tbl_neg_q;
    cycle_start_d = 1'b0;

    if (sample_en && state_q != STALLED) begin
      tbl_valid_d = 1'b1;
      if (state_q == RUNNING && run) begin
        phase_d       = sum_c[PHASE_W-1:0];
        cycle_start_d = sum_c[PHASE_W];
      end else begin
        phase_d = '0;
      end
      state_d = run ? RUNNING : STOPPED;
    end

    // Quadrants 1 and 3 walk the table backwards.
    quad = phase_d[PHASE_W-1 -: 2];
    idx  = phase_d[PHASE_W-3 -: ADDR_W];
    if (tbl_valid_d) begin
      tbl_addr_d = quad[0] ? ~idx : idx;
      tbl_neg_d  = quad[1];
    end

`ifdef SAMPLE_WDOG_EN
    wdog_d = wdog_q;
    if (state_q != STALLED) begin
      wdog_d = sample_en ? '0 : WDOG_W'(wdog_q + 1'b1);
      if (wdog_d == WDOG_W'(WDOG_LIMIT)) begin
        state_d = STALLED;
      end
    end
`endif
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q       <= STOPPED;
      phase_q       <= '0;
      ftw_shadow_q  <= '0;
      ftw_active_q  <= '0;
      tbl_valid_q   <= 1'b0;
      tbl_addr_q    <= '0;
      tbl_neg_q     <= 1'b0;
      cycle_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      ftw_shadow_q  <= ftw_shadow_d;
      ftw_active_q  <= ftw_active_d;
      tbl_valid_q   <= tbl_valid_d;
      tbl_addr_q    <= tbl_addr_d;
      tbl_neg_q     <= tbl_neg_d;
      cycle_start_q <= cycle_start_d;
    end
  end

`ifdef SAMPLE_WDOG_EN
  // Stall is sticky: only reset leaves STALLED.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      wdog_q  <= '0;
      stall_q <= 1'b0;
    end else begin
      wdog_q  <= wdog_d;
      stall_q <= (state_d == STALLED);
    end
  end

  assign stall = stall_q;
`else
  assign stall = 1'b0;
`endif

  assign tbl_valid   = tbl_valid_q;
  assign tbl_addr    = tbl_addr_q;
  assign tbl_neg     = tbl_neg_q;
  assign cycle_start = cycle_start_q;

endmodule

// File: tb/tb_sample_phase_gen.sv
// Randomised bench for sample_phase_gen against a sample-level reference model,
// with directed sequences for the documented scenarios.
module tb_sample_phase_gen;
  import sample_phase_pkg::*;

  localparam int unsigned PW   = DEF_PHASE_W;
  localparam int unsigned AW   = DEF_ADDR_W;
  localparam int unsigned WL   = DEF_WDOG_LIMIT;
  localparam int unsigned MAXC = 60000;
  localparam longint unsigned MOD = 64'd1 << PW;

  logic          clk_in = 1'b0;
  logic          reset, sample_clk, run, ftw_load;
  logic [PW-1:0] ftw;
  logic          sample_en, tbl_valid, tbl_neg, cycle_start, stall;
  logic [AW-1:0] tbl_addr;

  sample_phase_gen dut (
    .clk_in      (clk_in),
    .reset       (reset),
    .sample_clk  (sample_clk),
    .run         (run),
    .ftw         (ftw),
    .ftw_load    (ftw_load),
    .sample_en   (sample_en),
    .tbl_valid   (tbl_valid),
    .tbl_addr    (tbl_addr),
    .tbl_neg     (tbl_neg),
    .cycle_start (cycle_start),
    .stall       (stall)
  );

  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: sample_clk history plus sample-level phase arithmetic.
  bit              clkhist [MAXC];
  int              cyc = 0;
  int              last_rst = -1;
  longint unsigned m_phase, m_shadow, m_active;
  int unsigned     m_addr;
  bit              m_running, m_stalled, m_valid, m_neg, m_cs, m_se;
  int              m_gap;
  bit              sc_auto = 1'b0;
  int              sc_cnt = 0;

  // The synchroniser forgets everything seen up to and including a reset cycle.
  function automatic bit hist(input int t);
    if (t < 0 || t <= last_rst) return 1'b0;
    return clkhist[t];
  endfunction

  task automatic model_edge();
    longint unsigned tot, q, ix;
    clkhist[cyc] = sample_clk;
    if (reset) begin
      last_rst  = cyc;
      m_phase   = 0; m_shadow = 0; m_active = 0; m_addr = 0;
      m_running = 0; m_stalled = 0; m_valid = 0; m_neg = 0; m_cs = 0;
      m_gap     = 0;
      return;
    end
    m_valid = 0;
    m_cs    = 0;
    if (m_se && !m_stalled) begin
      m_valid = 1;
      if (m_running && run) begin
        tot     = m_phase + m_active;
        m_cs    = (tot >= MOD);
        m_phase = tot % MOD;
      end else begin
        m_phase = 0;
      end
      m_running = run;
      q      = m_phase >> (PW - 2);
      ix     = (m_phase >> (PW - 2 - AW)) % (64'd1 << AW);
      m_addr = int'((q % 2 == 1) ? ((64'd1 << AW) - 1 - ix) : ix);
      m_neg  = (q >= 2);
    end
    if (m_se) m_active = m_shadow;
    if (ftw_load) m_shadow = longint'(ftw);
`ifdef SAMPLE_WDOG_EN
    if (!m_stalled) begin
      m_gap = m_se ? 0 : m_gap + 1;
      if (m_gap == int'(WL)) m_stalled = 1;
    end
`endif
  endtask

  task automatic tick();
    @(posedge clk_in);
    model_edge();
    cyc++;
    if (cyc >= int'(MAXC) - 2) begin
      $display("FAIL cycle_budget: got %0d expected below %0d", cyc, MAXC);
      $fatal(1, "cycle budget exhausted");
    end
    @(negedge clk_in);
    // A rise seen in cycle k pulses sample_en in cycle k+2.
    m_se = hist(cyc - 2) & ~hist(cyc - 3);
    check_val("sample_en",   32'(sample_en),   32'(m_se));
    check_val("tbl_valid",   32'(tbl_valid),   32'(m_valid));
    check_val("tbl_addr",    32'(tbl_addr),    m_addr);
    check_val("tbl_neg",     32'(tbl_neg),     32'(m_neg));
    check_val("cycle_start", 32'(cycle_start), 32'(m_cs));
    check_val("stall",       32'(stall),       32'(m_stalled));
    if (sc_auto) begin
      if (sc_cnt == 0) begin
        sample_clk = ~sample_clk;
        sc_cnt = int'($urandom_range(2, 10));
      end else begin
        sc_cnt--;
      end
    end
  endtask

  task automatic wait_valid(output logic [AW-1:0] a, output logic n, output logic c);
    int k = 0;
    do begin
      tick();
      k++;
    end while (!tbl_valid && k < 200);
    if (!tbl_valid) check_val("valid_timeout", 32'(k), 32'd0);
    a = tbl_addr;
    n = tbl_neg;
    c = cycle_start;
  endtask

  task automatic skip_se();
    int k = 0;
    while (m_se && k < 10) begin
      tick();
      k++;
    end
  endtask

  logic [AW-1:0] a;
  logic          n, c;

  initial begin
    int lat;
    int unsigned exp_a [4];
    bit          exp_n [4];
    reset = 1'b1; sample_clk = 1'b0; run = 1'b0; ftw = '0; ftw_load = 1'b0;

    // 1: reset while sample_clk toggles, then first-edge latency.
    tick(); sample_clk = 1'b1;
    tick(); sample_clk = 1'b0;
    check_val("rst_valid", 32'(tbl_valid), 32'd0);
    check_val("rst_addr",  32'(tbl_addr),  32'd0);
    check_val("rst_neg",   32'(tbl_neg),   32'd0);
    check_val("rst_cs",    32'(cycle_start), 32'd0);
    check_val("rst_stall", 32'(stall),     32'd0);
    reset = 1'b0;
    repeat (4) tick();
    sample_clk = 1'b1;
    lat = 1;
    while (!sample_en && lat < 10) begin
      tick();
      lat++;
    end
    check_val("se_latency", 32'(lat), 32'd3);
    sc_auto = 1'b1;
    sc_cnt  = 4;

    // 2: quarter-turn steps through all four quadrants.
    skip_se();
    run = 1'b1; ftw = 24'h400000; ftw_load = 1'b1;
    tick(); ftw_load = 1'b0;
    wait_valid(a, n, c);
    check_val("q_start_addr", 32'(a), 32'd0);
    exp_a = '{255, 0, 255, 0};
    exp_n = '{0, 1, 1, 0};
    for (int i = 0; i < 4; i++) begin
      wait_valid(a, n, c);
      check_val("q_addr", 32'(a), exp_a[i]);
      check_val("q_neg",  32'(n), 32'(exp_n[i]));
      check_val("q_cs",   32'(c), (i == 3) ? 32'd1 : 32'd0);
    end

    // 3: fine sweep through the first quadrant and into the mirrored one.
    run = 1'b0;
    wait_valid(a, n, c);
    skip_se();
    ftw = 24'h004000; ftw_load = 1'b1; run = 1'b1;
    tick(); ftw_load = 1'b0;
    wait_valid(a, n, c);
    check_val("sw_start", 32'(a), 32'd0);
    for (int i = 1; i <= 256; i++) begin
      wait_valid(a, n, c);
      if (i <= 3 || i >= 255) begin
        check_val("sw_addr", 32'(a), (i == 256) ? 32'd255 : 32'(i));
        check_val("sw_neg",  32'(n), 32'd0);
      end
    end

    // 5: dropping run clears the phase at the next sample.
    run = 1'b0;
    wait_valid(a, n, c);
    check_val("stop_addr", 32'(a), 32'd0);
    check_val("stop_neg",  32'(n), 32'd0);
    check_val("stop_cs",   32'(c), 32'd0);
    wait_valid(a, n, c);
    check_val("stop_hold", 32'(a), 32'd0);

    // 4: tuning word loaded on a sample_en cycle only becomes active there.
    run = 1'b1;
    wait_valid(a, n, c);
    check_val("ld_start", 32'(a), 32'd0);
    lat = 0;
    while (!m_se && lat < 100) begin
      tick();
      lat++;
    end
    ftw = 24'h100000; ftw_load = 1'b1;
    tick(); ftw_load = 1'b0;
    check_val("ld_valid", 32'(tbl_valid), 32'd1);
    check_val("ld_addr0", 32'(tbl_addr), 32'd1);
    wait_valid(a, n, c);
    check_val("ld_addr1", 32'(a), 32'd2);
    wait_valid(a, n, c);
    check_val("ld_addr2", 32'(a), 32'd66);

    // Random traffic: run toggles, loads of edge-case and random words, resets.
    for (int i = 0; i < 15000; i++) begin
      tick();
      ftw_load = 1'b0;
      reset    = 1'b0;
      if ($urandom_range(0, 199) == 0) run = ~run;
      if ($urandom_range(0, 49) == 0) begin
        case ($urandom_range(0, 3))
          0:       ftw = '0;
          1:       ftw = '1;
          2:       ftw = PW'($urandom);
          default: ftw = 24'h400000;
        endcase
        ftw_load = 1'b1;
      end
      if ($urandom_range(0, 3999) == 0) reset = 1'b1;
    end
    ftw_load = 1'b0;
    reset    = 1'b0;
    tick();

`ifdef SAMPLE_WDOG_EN
    // 6: lost sample clock latches stall until reset.
    sc_auto = 1'b0; sample_clk = 1'b0; run = 1'b1;
    repeat (int'(WL) + 50) tick();
    check_val("wd_stall", 32'(stall), 32'd1);
    sc_auto = 1'b1;
    repeat (100) tick();
    check_val("wd_sticky", 32'(stall), 32'd1);
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
    check_val("wd_cleared", 32'(stall), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
